bcau_window_loader: RTL

//  Transmit side of the iru_valid/bcau_ready/iru_results interface into bcau.

---
 rtl/bcau_pkg.sv | 43 ++++
 rtl/bcau_window_loader_if.sv | 37 +++
 rtl/bcau_win_bank.sv | 31 +++
 rtl/bcau_window_loader.sv | 125 ++++++++++++
 4 files changed

// File: rtl/bcau_pkg.sv
// bcau_pkg
//   Shared sizes and types for the bcau window loader.
//   pix_t    : one pixel
//   band_t   : BAND_ROWS rows of a window, flattened row-major (BAND_PIX pixels)
//   window_t : N_BANDS bands, the layout bcau consumes on iru_results
//   band_of / offset_of map a raster (row, col) to its band and band offset.
package bcau_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN_DIM   = 20;
    localparam int BAND_ROWS = 4;
    localparam int N_BANDS   = WIN_DIM / BAND_ROWS;
    localparam int BAND_PIX  = BAND_ROWS * WIN_DIM;
    localparam int CNT_W     = 16;

    localparam int RC_W   = 5;
    localparam int BAND_W = $clog2(N_BANDS);
    localparam int K_W    = $clog2(BAND_PIX);

    typedef logic [PIX_W-1:0]  pix_t;
    typedef pix_t [BAND_PIX-1:0] band_t;
    typedef band_t [N_BANDS-1:0] window_t;

    typedef logic [RC_W-1:0]   rc_t;
    typedef logic [BAND_W-1:0] band_idx_t;
    typedef logic [K_W-1:0]    pix_idx_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam rc_t LAST_RC = rc_t'(WIN_DIM - 1);

    // Band holding raster row `row`.
    function automatic band_idx_t band_of(rc_t row);
        return band_idx_t'(row / rc_t'(BAND_ROWS));
    endfunction

    // Offset inside the band: rows of the band are laid end to end, so the
    // 4-pixel tile index (offset % WIN_DIM) / 4 equals col / 4.
    function automatic pix_idx_t offset_of(rc_t row, rc_t col);
        return pix_idx_t'(row % rc_t'(BAND_ROWS)) * pix_idx_t'(WIN_DIM)
               + pix_idx_t'(col);
    endfunction

endpackage

// File: rtl/bcau_window_loader_if.sv
// bcau_window_loader_if
//   Pixel stream in, packed window out to bcau.
//   pix_valid/pix_data/pix_last/pix_ready : raster pixel stream
//   iru_valid/bcau_ready/iru_results      : window handoff to bcau
//   frame_err                             : pix_last framing mismatch pulse
//   win_cnt                               : windows delivered to bcau
//
// Handshake: a pixel moves on a rising edge where pix_valid && pix_ready;
// a window moves on a rising edge where iru_valid && bcau_ready. Once
// iru_valid is high it and iru_results hold until that transfer edge.
// pix_ready depends on registers only, never on pix_valid.
//
// Modports: master = the loader, slave = the pixel source / bcau side.
interface bcau_window_loader_if;
    import bcau_pkg::*;

    logic    pix_valid;
    pix_t    pix_data;
    logic    pix_last;
    logic    pix_ready;
    logic    iru_valid;
    logic    bcau_ready;
    window_t iru_results;
    logic    frame_err;
    cnt_t    win_cnt;

    modport master (
        input  pix_valid, pix_data, pix_last, bcau_ready,
        output pix_ready, iru_valid, iru_results, frame_err, win_cnt
    );

    modport slave (
        output pix_valid, pix_data, pix_last, bcau_ready,
        input  pix_ready, iru_valid, iru_results, frame_err, win_cnt
    );

endinterface

// File: rtl/bcau_win_bank.sv
// bcau_win_bank
//   One window of pixel storage.
//   clk, rst : clock, asynchronous active-high reset (clears the store)
//   clr      : synchronous clear of the whole window, wins over we
//   we, j, k : write data into band j, offset k
//   data     : pixel to write
//   q        : whole stored window
module bcau_win_bank
    import bcau_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      we,
    input  band_idx_t j,
    input  pix_idx_t  k,
    input  pix_t      data,
    output window_t   q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (we) begin
            q[j][k] <= data;
        end
    end

endmodule

// File: rtl/bcau_window_loader.sv
// bcau_window_loader
//   Packs a raster-order WIN_DIM x WIN_DIM pixel stream into the band layout
//   bcau consumes. Two banks ping-pong: one fills while the other waits for
//   bcau.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, drops all partial and full windows
//   bus : bcau_window_loader_if.master (pixel stream in, window out,
//         frame_err, win_cnt)
module bcau_window_loader
    import bcau_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    bcau_window_loader_if.master        bus
);

    rc_t        row;
    rc_t        col;
    logic       wr_sel;
    logic       rd_sel;
    logic [1:0] full;
    logic [1:0] full_nxt;
    cnt_t       win_cnt_q;
    logic       frame_err_q;
    window_t    bank_q0;
    window_t    bank_q1;

    logic       accept;
    logic       at_end;
    logic       complete;
    logic       early;
    logic       xfer;
    band_idx_t  wr_j;
    pix_idx_t   wr_k;

    assign bus.pix_ready = ~full[wr_sel];
    assign bus.iru_valid = full[rd_sel];

    assign accept   = bus.pix_valid & bus.pix_ready;
    assign at_end   = (row == LAST_RC) && (col == LAST_RC);
    assign complete = accept & at_end;
    // pix_last before the final pixel aborts the window being filled.
    assign early    = accept & bus.pix_last & ~at_end;
    assign xfer     = bus.iru_valid & bus.bcau_ready;

    assign wr_j = band_of(row);
    assign wr_k = offset_of(row, col);

    // Completion and drain always target different banks (the filling bank
    // is not full, the draining one is), so both updates can apply together.
    always_comb begin
        full_nxt = full;
        if (xfer) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (complete) begin
            full_nxt[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            full        <= '0;
            win_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= (complete & ~bus.pix_last) | early;
            full        <= full_nxt;

            if (accept) begin
                if (complete || early) begin
                    row <= '0;
                    col <= '0;
                end else if (col == LAST_RC) begin
                    col <= '0;
                    row <= row + rc_t'(1);
                end else begin
                    col <= col + rc_t'(1);
                end
            end

            if (complete) begin
                wr_sel <= ~wr_sel;
            end

            if (xfer) begin
                rd_sel    <= ~rd_sel;
                win_cnt_q <= win_cnt_q + cnt_t'(1);
            end
        end
    end

    // The aborted partial window is wiped so stale pixels never leak into
    // a later window.
    bcau_win_bank u_bank0 (
        .clk  (clk),
        .rst  (rst),
        .clr  (early & ~wr_sel),
        .we   (accept & ~wr_sel),
        .j    (wr_j),
        .k    (wr_k),
        .data (bus.pix_data),
        .q    (bank_q0)
    );

    bcau_win_bank u_bank1 (
        .clk  (clk),
        .rst  (rst),
        .clr  (early & wr_sel),
        .we   (accept & wr_sel),
        .j    (wr_j),
        .k    (wr_k),
        .data (bus.pix_data),
        .q    (bank_q1)
    );

    assign bus.iru_results = rd_sel ? bank_q1 : bank_q0;
    assign bus.frame_err   = frame_err_q;
    assign bus.win_cnt     = win_cnt_q;

endmodule
